chart_recorder: RTL and testbench
=================================

CHART_RECORDER -- requirements
Module: chart_recorder

Interface
REQ-001 SHALL have parameter SLOTS, default 120, meaning number of note slots recorded; range 1..127.
REQ-002 SHALL have parameter BEAT_CYCLES, default 5000000, meaning clk cycles per slot; range 2 or more.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_b, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, level sampled each cycle; high starts or restarts a recording.
REQ-006 SHALL have port KEY, input, 4, raw active-low push buttons; KEY[3] is ignored.
REQ-007 SHALL have port stream, output, 2*SLOTS, recorded chart; slot k occupies bits [2k+1:2k].
REQ-008 SHALL have port slot_idx, output, 7, index of the slot currently being recorded.
REQ-009 SHALL have port cur_code, output, 2, code latched so far in the current slot.
REQ-010 SHALL have port beat, output, 1, one-cycle pulse on each slot commit.
REQ-011 SHALL have port note_count, output, 8, number of non-zero codes committed.
REQ-012 SHALL have port recording, output, 1, high while in state REC.
REQ-013 SHALL have port done, output, 1, high while in state DONE.

Function
REQ-014 SHALL pass each KEY bit through a two-flop synchronizer, then detect a press as a registered 1-to-0 transition, giving a one-cycle press pulse 3 clk cycles after the pin falls.
REQ-015 SHALL encode presses with the playback codes: KEY[1] to 01, KEY[2] to 10, KEY[0] to 11, no press to 00.
REQ-016 SHALL, for press pulses in the same cycle, apply priority KEY[1] over KEY[2] over KEY[0].
REQ-017 SHALL implement the states IDLE, REC and DONE.
REQ-018 SHALL, on start high in any state, enter REC and perform the following in the same edge: clear stream, slot_idx, cur_code and note_count to 0, and load the beat counter with BEAT_CYCLES-1.
REQ-019 SHALL, in REC, latch only the first press of a slot into cur_code; later presses in that slot are ignored.
REQ-020 SHALL, in REC, decrement the beat counter each cycle; when the counter is 0, commit the slot in that cycle.
REQ-021 SHALL, on a slot commit, write the slot code into stream bits [2*slot_idx+1:2*slot_idx], pulse beat, add 1 to note_count if the code is non-zero, clear cur_code, reload the counter with BEAT_CYCLES-1, and increment slot_idx.
REQ-022 SHALL, when the commit cycle has an empty cur_code and a press pulse, commit that press's code.
REQ-023 SHALL, when the commit is for slot SLOTS-1, enter DONE and leave slot_idx at SLOTS-1 (no wrap).
REQ-024 SHALL, in DONE, hold stream and note_count constant, ignore KEY, keep beat low and hold done high until start or reset.
REQ-025 SHALL, in IDLE, ignore KEY and keep stream unchanged.
REQ-026 SHALL let start override any commit in the same cycle: no commit, no beat pulse, restart per REQ-018.
REQ-027 SHALL not saturate note_count, since its maximum value is SLOTS (127 or less).

Reset
REQ-028 SHALL, while reset_b is low at a clk edge, enter IDLE and clear stream, slot_idx, cur_code, note_count, beat, recording, done and the beat counter to 0, and set the synchronizer and edge flops to 1 (released key).
REQ-029 SHALL give reset_b priority over start, including reset asserted mid-recording, which discards the partial chart.

Verification (SLOTS=4, BEAT_CYCLES=4)
REQ-030 SHALL cover: reset, start, then press KEY[1], KEY[2], KEY[0] and none in slots 0-3 -> stream=8'b00_11_10_01, note_count=3, 4 beat pulses spaced 4 cycles apart, done=1.
REQ-031 SHALL cover: two presses (KEY[2] then KEY[0]) in slot 0 -> slot 0 code=10.
REQ-032 SHALL cover: KEY[1] and KEY[2] falling in the same cycle -> code 01.
REQ-033 SHALL cover: press pulse arriving in the commit cycle of an empty slot 1 -> stream[3:2] holds that code, slot 2 stays 00 from that press.
REQ-034 SHALL cover: start held high in slot 2 -> stream=0, slot_idx=0, note_count=0, and no beat pulse that cycle.
REQ-035 SHALL cover: reset_b low during slot 1 -> outputs all 0, recording=0; presses after release leave stream=0 until start.

Source files
------------

// File: rtl/chart_recorder.sv
// Records one 2-bit note code per beat slot from three debounced-by-sync push buttons.
// Start (re)arms a recording; the chart is frozen once the last slot commits.
module chart_recorder #(
  parameter int unsigned SLOTS       = 120,
  parameter int unsigned BEAT_CYCLES = 5000000
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               start,
  input  logic [3:0]         KEY,
  output logic [2*SLOTS-1:0] stream,
  output logic [6:0]         slot_idx,
  output logic [1:0]         cur_code,
  output logic               beat,
  output logic [7:0]         note_count,
  output logic               recording,
  output logic               done
);

  localparam int unsigned CW = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REC, S_DONE} state_t;

  state_t             r_state;
  logic [2:0]         r_sync1, r_sync2, r_prev, r_press;
  logic [CW-1:0]      r_cnt;
  logic [2*SLOTS-1:0] r_stream;
  logic [6:0]         r_slot_idx;
  logic [1:0]         r_cur_code;
  logic               r_beat;
  logic [7:0]         r_note_count;
  logic               r_recording;
  logic               r_done;
  logic [1:0]         w_press_code;
  logic [1:0]         w_commit_code;
  logic               w_unused_key3;

  assign w_unused_key3 = KEY[3];

  // Press pulse lands one cycle after the second sync flop sees the fall.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_press <= '0;
    end else begin
      r_sync1 <= KEY[2:0];
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_press <= r_prev & ~r_sync2;
    end
  end

  always_comb begin
    w_press_code = 2'b00;
    if (r_press[1])      w_press_code = 2'b01;
    else if (r_press[2]) w_press_code = 2'b10;
    else if (r_press[0]) w_press_code = 2'b11;
    w_commit_code = (r_cur_code != 2'b00) ? r_cur_code : w_press_code;
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_stream     <= '0;
      r_slot_idx   <= '0;
      r_cur_code   <= '0;
      r_beat       <= 1'b0;
      r_note_count <= '0;
      r_recording  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_beat <= 1'b0;
      if (start) begin
        r_state      <= S_REC;
        r_cnt        <= CW'(BEAT_CYCLES - 1);
        r_stream     <= '0;
        r_slot_idx   <= '0;
        r_cur_code   <= '0;
        r_note_count <= '0;
        r_recording  <= 1'b1;
        r_done       <= 1'b0;
      end else begin
        case (r_state)
          S_REC: begin
            if (r_cnt == '0) begin
              for (int unsigned k = 0; k < SLOTS; k++) begin
                if (r_slot_idx == 7'(k)) r_stream[2*k +: 2] <= w_commit_code;
              end
              r_beat       <= 1'b1;
              r_note_count <= r_note_count + 8'(w_commit_code != 2'b00);
              r_cur_code   <= '0;
              r_cnt        <= CW'(BEAT_CYCLES - 1);
              if (r_slot_idx == 7'(SLOTS - 1)) begin
                r_state     <= S_DONE;
                r_recording <= 1'b0;
                r_done      <= 1'b1;
              end else begin
                r_slot_idx <= r_slot_idx + 7'd1;
              end
            end else begin
              r_cnt <= r_cnt - CW'(1);
              if (r_cur_code == 2'b00) r_cur_code <= w_press_code;
            end
          end
          S_DONE:  r_done <= 1'b1;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign stream     = r_stream;
  assign slot_idx   = r_slot_idx;
  assign cur_code   = r_cur_code;
  assign beat       = r_beat;
  assign note_count = r_note_count;
  assign recording  = r_recording;
  assign done       = r_done;

endmodule

// File: tb/tb_chart_recorder.sv
// Directed bench for chart_recorder with SLOTS=4, BEAT_CYCLES=4.
// A key fall sampled at edge F is consumed by the recorder at edge F+3.
module tb_chart_recorder;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       start;
  logic [3:0] KEY;
  logic [7:0] stream;
  logic [6:0] slot_idx;
  logic [1:0] cur_code;
  logic       beat;
  logic [7:0] note_count;
  logic       recording;
  logic       done;

  int checks   = 0;
  int failures = 0;

  chart_recorder #(.SLOTS(4), .BEAT_CYCLES(4)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .KEY(KEY),
    .stream(stream), .slot_idx(slot_idx), .cur_code(cur_code), .beat(beat),
    .note_count(note_count), .recording(recording), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stream"}, 32'(stream), 32'h0);
    chk({tag, "_slot"},   32'(slot_idx), 32'h0);
    chk({tag, "_cur"},    32'(cur_code), 32'h0);
    chk({tag, "_beat"},   32'(beat), 32'h0);
    chk({tag, "_notes"},  32'(note_count), 32'h0);
    chk({tag, "_rec"},    32'(recording), 32'h0);
    chk({tag, "_done"},   32'(done), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_b = 1'b0; start = 1'b0; KEY = 4'b1111;
    repeat (3) tick();
    chk_all_zero("reset");
    reset_b = 1'b1;
    tick();

    // Recording A: KEY1, KEY2, KEY0, none across slots 0..3
    start = 1'b1; tick(); start = 1'b0;
    chk("A_rec", 32'(recording), 32'h1);
    for (int c = 1; c <= 24; c++) begin
      KEY = (c == 1)  ? 4'b1101 :
            (c == 3)  ? 4'b1011 :
            (c == 7)  ? 4'b1110 :
            (c == 18) ? 4'b1101 : 4'b1111;
      tick();
      chk($sformatf("A_beat_c%0d", c), 32'(beat), 32'((c % 4 == 0) && (c <= 16)));
      if (c == 6) begin
        chk("A_cur_slot1", 32'(cur_code), 32'h2);
        chk("A_idx_slot1", 32'(slot_idx), 32'h1);
      end
      if (c == 16) chk("A_done16", 32'(done), 32'h1);
    end
    chk("A_stream",  32'(stream), 32'b00_11_10_01);
    chk("A_notes",   32'(note_count), 32'h3);
    chk("A_done",    32'(done), 32'h1);
    chk("A_rec_off", 32'(recording), 32'h0);
    chk("A_idx",     32'(slot_idx), 32'h3);

    // Recording B: two presses in slot 0, simultaneous KEY1/KEY2 in slot 1, start at slot-2 commit
    start = 1'b1; KEY = 4'b1011; tick(); start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      KEY = (c == 1) ? 4'b1110 : (c == 4) ? 4'b1001 : 4'b1111;
      tick();
      if (c == 3) chk("B_cur_first", 32'(cur_code), 32'h2);
      if (c == 4) begin
        chk("B_beat4",  32'(beat), 32'h1);
        chk("B_slot0",  32'(stream[1:0]), 32'h2);
      end
      if (c == 8) begin
        chk("B_stream8", 32'(stream), 32'b00_00_01_10);
        chk("B_notes8",  32'(note_count), 32'h2);
        chk("B_idx8",    32'(slot_idx), 32'h2);
      end
    end
    start = 1'b1; tick(); start = 1'b0;
    chk("B_rst_stream", 32'(stream), 32'h0);
    chk("B_rst_idx",    32'(slot_idx), 32'h0);
    chk("B_rst_notes",  32'(note_count), 32'h0);
    chk("B_rst_beat",   32'(beat), 32'h0);
    chk("B_rst_rec",    32'(recording), 32'h1);

    // Recording C: KEY0 press consumed exactly at the commit of empty slot 1
    for (int c = 1; c <= 16; c++) begin
      KEY = (c == 5) ? 4'b1110 : 4'b1111;
      tick();
      chk($sformatf("C_beat_c%0d", c), 32'(beat), 32'(c % 4 == 0));
      if (c == 8) begin
        chk("C_slot1",  32'(stream[3:2]), 32'h3);
        chk("C_cur8",   32'(cur_code), 32'h0);
      end
    end
    chk("C_stream", 32'(stream), 32'b00_00_11_00);
    chk("C_notes",  32'(note_count), 32'h1);
    chk("C_done",   32'(done), 32'h1);

    // Recording D: reset mid-recording discards the chart
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      KEY = (c == 1) ? 4'b1101 : 4'b1111;
      tick();
      if (c == 4) chk("D_slot0", 32'(stream), 32'h1);
    end
    reset_b = 1'b0; tick();
    chk_all_zero("D_reset");
    reset_b = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      KEY = (c == 1) ? 4'b1101 : (c == 3) ? 4'b1110 : 4'b1111;
      tick();
    end
    chk("D_idle_stream", 32'(stream), 32'h0);
    chk("D_idle_notes",  32'(note_count), 32'h0);
    chk("D_idle_rec",    32'(recording), 32'h0);

    // Reset outranks start in the same cycle
    reset_b = 1'b0; start = 1'b1; tick();
    chk("R_over_start_rec", 32'(recording), 32'h0);
    reset_b = 1'b1; start = 1'b0; tick();
    chk("R_after_rec", 32'(recording), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
